// File: rtl/add_normalize_pack.sv
// Purpose: normalize, round (nearest-even) and pack an add/sub magnitude into IEEE-754 single.
// Latency: 1 cycle for zero/inf inputs, 3+L cycles otherwise (L = left shifts, up to 25).
// Backpressure: one operand set in flight; result held in DONE until ready_in, ready_out only in IDLE.
module add_normalize_pack (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [26:0] frac_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] result_out,
    output logic        overflow_out,
    output logic        underflow_out,
    output logic        inexact_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [26:0] frac_q, frac_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inx_q, inx_d;

    // Rounding datapath: 24-bit mantissa (hidden one included) plus the RNE increment.
    logic        round_up;
    logic [24:0] mant_sum;
    logic [8:0]  exp_rnd;
    logic [22:0] mant_rnd;

    // Round-to-nearest-even; a carry out of the hidden bit renormalizes to 1.0 and bumps exp.
    always_comb begin
        round_up = frac_q[1] & (frac_q[0] | frac_q[2]);
        mant_sum = {1'b0, frac_q[25:2]} + {24'h0, round_up};
        exp_rnd  = {1'b0, exp_q} + {8'h0, mant_sum[24]};
        mant_rnd = mant_sum[24] ? 23'h0 : mant_sum[22:0];
    end

    // Next-state and datapath control; everything holds unless a state says otherwise.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    sign_d = sign_in;
                    exp_d  = exp_in;
                    frac_d = frac_in;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    inx_d  = 1'b0;
                    if (frac_in == 27'h0) begin
                        result_d = {sign_in, 31'h0};
                        state_d  = DONE;
                    end else if (exp_in == 8'hFF) begin
                        result_d = {sign_in, 8'hFF, 23'h0};
                        ovf_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (frac_q[26]) begin
                    // Carry out of the adder: shift right, folding the dropped bit into sticky.
                    frac_d  = {1'b0, frac_q[26:2], frac_q[1] | frac_q[0]};
                    exp_d   = exp_q + 8'd1;
                    state_d = ROUND;
                end else if (frac_q[25]) begin
                    state_d = ROUND;
                end else if (exp_q <= 8'd1) begin
                    // Another left shift would reach the denormal range: flush to zero.
                    result_d = {sign_q, 31'h0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    inx_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    frac_d = {frac_q[25:0], 1'b0};
                    exp_d  = exp_q - 8'd1;
                end
            end

            ROUND: begin
                unf_d = 1'b0;
                if (exp_rnd >= 9'd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], mant_rnd};
                    ovf_d    = 1'b0;
                    inx_d    = frac_q[1] | frac_q[0];
                end
                state_d = DONE;
            end

            DONE: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operand set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 8'h0;
            frac_q   <= 27'h0;
            result_q <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        ready_out     = (state_q == IDLE);
        valid_out     = (state_q == DONE);
        result_out    = result_q;
        overflow_out  = ovf_q;
        underflow_out = unf_q;
        inexact_out   = inx_q;
    end

endmodule

// File: tb/tb_add_normalize_pack.sv
// Purpose: directed self-checking bench for add_normalize_pack with an expected-result scoreboard.
// Latency: measured per transaction from the acceptance edge to valid_out.
// Backpressure: holds ready_in low in DONE and checks the result stays frozen.
module tb_add_normalize_pack;

    logic        CLK;
    logic        RST;
    logic        valid_in;
    logic        ready_out;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [26:0] frac_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result_out;
    logic        overflow_out;
    logic        underflow_out;
    logic        inexact_out;

    add_normalize_pack dut (
        .CLK          (CLK),
        .RST          (RST),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .sign_in      (sign_in),
        .exp_in       (exp_in),
        .frac_in      (frac_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .result_out   (result_out),
        .overflow_out (overflow_out),
        .underflow_out(underflow_out),
        .inexact_out  (inexact_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one operand set, wait for the result, compare against the scoreboard head,
    // then stall the output for 'hold' cycles before completing the handshake.
    task automatic send(input logic s, input logic [7:0] e, input logic [26:0] f,
                        input logic [31:0] r, input logic o, input logic u, input logic x,
                        input int lat, input int hold);
        exp_t it;
        int   cnt;
        it.res = r; it.ovf = o; it.unf = u; it.inx = x; it.lat = lat;
        sb.push_back(it);
        n_vec++;
        @(negedge CLK);
        chk("ready_before_accept", {31'h0, ready_out}, 32'h1);
        sign_in  = s;
        exp_in   = e;
        frac_in  = f;
        valid_in = 1'b1;
        @(posedge CLK);
        #1;
        valid_in = 1'b0;
        cnt = 1;
        while (valid_out !== 1'b1 && cnt < 60) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        it = sb.pop_front();
        chk("valid_out", {31'h0, valid_out}, 32'h1);
        if (it.lat > 0) chk("latency", cnt, it.lat);
        chk("result", result_out, it.res);
        chk("overflow", {31'h0, overflow_out}, {31'h0, it.ovf});
        chk("underflow", {31'h0, underflow_out}, {31'h0, it.unf});
        chk("inexact", {31'h0, inexact_out}, {31'h0, it.inx});
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            chk("hold_valid", {31'h0, valid_out}, 32'h1);
            chk("hold_ready", {31'h0, ready_out}, 32'h0);
            chk("hold_result", result_out, it.res);
            chk("hold_flags", {29'h0, overflow_out, underflow_out, inexact_out},
                {29'h0, it.ovf, it.unf, it.inx});
        end
        @(negedge CLK);
        ready_in = 1'b1;
        @(posedge CLK);
        #1;
        ready_in = 1'b0;
        chk("release_valid", {31'h0, valid_out}, 32'h0);
        chk("release_ready", {31'h0, ready_out}, 32'h1);
    endtask

    initial begin
        RST      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        sign_in  = 1'b0;
        exp_in   = 8'h0;
        frac_in  = 27'h0;

        // Reset values before any clock edge.
        #3;
        chk("rst_ready", {31'h0, ready_out}, 32'h1);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_result", result_out, 32'h0);
        chk("rst_flags", {29'h0, overflow_out, underflow_out, inexact_out}, 32'h0);
        @(posedge CLK);
        #1;
        chk("rst_hold_ready", {31'h0, ready_out}, 32'h1);
        @(negedge CLK);
        RST = 1'b0;

        // Carry normalize.
        send(1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 3, 0);
        // Long normalize: 23 left shifts.
        send(1'b0, 8'd127, 27'h0000004, 32'h34000000, 1'b0, 1'b0, 1'b0, 26, 0);
        // Zero, positive and negative.
        send(1'b0, 8'd127, 27'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1, 0);
        send(1'b1, 8'd50, 27'h0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1, 0);
        // Underflow during left normalization.
        send(1'b0, 8'd3, 27'h0000004, 32'h00000000, 1'b0, 1'b1, 1'b0, 0, 0);
        // Rounding carry out of the mantissa.
        send(1'b0, 8'd127, 27'h3FFFFFF, 32'h40000000, 1'b0, 1'b0, 1'b1, 3, 0);
        // Ties: even mantissa stays, odd mantissa rounds up.
        send(1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 1'b1, 3, 0);
        send(1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 1'b1, 3, 0);
        // Overflow from carry normalize at the top exponent.
        send(1'b1, 8'd254, 27'h4000000, 32'hFF800000, 1'b1, 1'b0, 1'b1, 3, 0);
        // Infinity/NaN exponent on input.
        send(1'b0, 8'hFF, 27'h0001234, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1, 0);
        // Back-pressure: five stalled cycles in DONE.
        send(1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 3, 5);

        // Reset in mid-NORM discards the in-flight operand set.
        @(negedge CLK);
        sign_in  = 1'b0;
        exp_in   = 8'd127;
        frac_in  = 27'h0000004;
        valid_in = 1'b1;
        @(posedge CLK);
        #1;
        valid_in = 1'b0;
        chk("norm_ready", {31'h0, ready_out}, 32'h0);
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, valid_out}, 32'h0);
        chk("midrst_ready", {31'h0, ready_out}, 32'h1);
        chk("midrst_result", result_out, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // First operand set after reset is processed normally.
        send(1'b1, 8'd127, 27'h2000000, 32'hBF800000, 1'b0, 1'b0, 1'b0, 3, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add_normalize_pack.md
ADD_NORMALIZE_PACK -- requirements
Module: add_normalize_pack

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- valid_in  in  1  upstream presents an operand set.
- ready_out  out  1  block can accept an operand set.
- sign_in  in  1  sign of the add/sub result.
- exp_in  in  8  biased exponent, the larger exponent from the alignment stage.
- frac_in  in  27  unsigned magnitude: bit26 carry, bit25 hidden one, bits24:2 fraction, bit1 guard, bit0 sticky/round.
- valid_out  out  1  result and flags are valid.
- ready_in  in  1  downstream accepts the result.
- result_out  out  32  packed IEEE-754 single-precision result.
- overflow_out  out  1  result saturated to infinity.
- underflow_out  out  1  result flushed to zero.
- inexact_out  out  1  nonzero bits were discarded by rounding.

Function
REQ-002 The FSM SHALL have four states: IDLE, NORM, ROUND and DONE.
REQ-003 ready_out SHALL be 1 exactly when the state is IDLE.
REQ-004 valid_out SHALL be 1 exactly when the state is DONE.
REQ-005 An operand set SHALL be accepted on a rising edge where valid_in=1 and ready_out=1, and sign_in, exp_in and frac_in SHALL be latched into internal registers on that edge.
REQ-006 When accepting an operand set in IDLE:
- frac_in=0: go to DONE with result {sign_in, 31'h0} and all flags 0.
- exp_in=8'hFF: go to DONE with result {sign_in, 8'hFF, 23'h0} and overflow_out=1.
- otherwise: go to NORM.
REQ-007 NORM SHALL perform one step per cycle:
- frac[26]=1: shift frac right by 1 with new bit0 = old bit1 | old bit0, increment exp, go to ROUND.
- else frac[25]=1: go to ROUND.
- else: shift frac left by 1 with a 0 fill, decrement exp, and stay in NORM.
REQ-008 If a NORM left shift would make exp equal 0, the block SHALL go to DONE with result {sign, 31'h0}, underflow_out=1 and inexact_out=0.
REQ-009 ROUND SHALL use round-to-nearest-even: increment mantissa bits[25:2] when frac[1]=1 and (frac[0]=1 or frac[2]=1).
REQ-010 In ROUND, inexact_out SHALL be set to frac[1] | frac[0].
REQ-011 If the rounding increment carries out of bit25, the mantissa SHALL become 1.0 and exp SHALL increment.
REQ-012 If exp equals 8'hFF after ROUND, the result SHALL be {sign, 8'hFF, 23'h0} with overflow_out=1 and inexact_out=1.
REQ-013 Otherwise ROUND SHALL produce the result {sign, exp, frac[24:2]} and go to DONE.
REQ-014 DONE SHALL hold result_out and all flags stable while ready_in=0, and SHALL return to IDLE on the edge where ready_in=1.
REQ-015 No new operand set SHALL be accepted in the cycle the block leaves DONE; ready_out rises the following cycle.
REQ-016 Latency from the acceptance edge to valid_out=1 SHALL be 1 cycle for the zero and exp=FF cases, and 3+L cycles otherwise, where L is the number of left shifts (maximum 25).
REQ-017 Outputs SHALL be driven only from registered state, with no combinational path from valid_in or ready_in to any output.
REQ-018 valid_in SHALL be ignored in NORM, ROUND and DONE.
REQ-019 The block SHALL hold at most one operand set at a time.

Reset
REQ-020 While RST=1, the state SHALL be IDLE immediately, without waiting for a clock edge.
REQ-021 While RST=1, the outputs SHALL be: valid_out=0, ready_out=1, result_out=32'h0, and all flags 0.
REQ-022 Asserting RST in NORM, ROUND or DONE SHALL discard the in-flight operand set with no output produced.
REQ-023 The first operand set after RST is deasserted SHALL be accepted on the first clock edge with valid_in=1.

Verification
REQ-024 Carry normalize: sign_in=0, exp_in=127, frac_in=27'h4000000 -> result_out=32'h40000000, flags 0, valid_out 3 cycles after acceptance.
REQ-025 Long normalize: exp_in=127, frac_in=27'h0000004 -> 23 left shifts, result_out=32'h34000000, valid_out 26 cycles after acceptance.
REQ-026 Zero and underflow:
- frac_in=0 -> result_out=32'h00000000 after 1 cycle.
- exp_in=3, frac_in=27'h0000004 -> result_out=32'h00000000, underflow_out=1.
REQ-027 Rounding carry: exp_in=127, frac_in=27'h3FFFFFF -> result_out=32'h40000000, inexact_out=1.
REQ-028 Overflow: sign_in=1, exp_in=254, frac_in=27'h4000000 -> result_out=32'hFF800000, overflow_out=1.
REQ-029 Back-pressure and reset: hold ready_in=0 for 5 cycles in DONE -> result stable and ready_out=0; then pulse RST in mid-NORM -> valid_out=0 and ready_out=1 immediately, and the next operand set is processed correctly.
